// File: rtl/if_id_reg.sv
// IF/ID pipeline register between the fetch (PC) stage and decode.
// Captures PC, PC+4 and the fetched instruction every cycle, supports stall
// (hold) and flush (bubble insertion for taken branches/jumps), pre-decodes
// the standard RISC-V fields, flags illegal opcodes, counts accepted
// instructions and bubble cycles, and produces the PC-register enable.
module if_id_reg #(
   parameter logic [31:0] NOP_INSTR = 32'h00000013,
   parameter logic [31:0] RESET_PC  = 32'h00000000,
   parameter int          CNT_W     = 32
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_stall,
   input  logic             i_flush,
   input  logic [31:0]      i_pc,
   input  logic [31:0]      i_inc_pc,
   input  logic [31:0]      i_instr,
   output logic             o_if_en,
   output logic             o_valid,
   output logic [31:0]      o_pc,
   output logic [31:0]      o_inc_pc,
   output logic [31:0]      o_instr,
   output logic [6:0]       o_opcode,
   output logic [4:0]       o_rd,
   output logic [2:0]       o_funct3,
   output logic [4:0]       o_rs1,
   output logic [4:0]       o_rs2,
   output logic [6:0]       o_funct7,
   output logic             o_illegal,
   output logic [CNT_W-1:0] o_acc_cnt,
   output logic [CNT_W-1:0] o_bub_cnt
);

   // PC+4 value that matches RESET_PC, so the pair stays consistent after reset.
   localparam logic [31:0] RESET_INC_PC = RESET_PC + 32'd4;

   // Counter increment, sized to the counter width so wrap is a plain modulo add.
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   // What the register bank does on the coming edge, in priority order.
   typedef enum logic [1:0] {
      UPD_LOAD  = 2'd0,
      UPD_STALL = 2'd1,
      UPD_FLUSH = 2'd2,
      UPD_RESET = 2'd3
   } upd_e;

   upd_e upd_sel;
   logic in_illegal;

   // Opcode legality check; only the low seven bits matter.
   function automatic logic is_illegal(input logic [6:0] op);
      logic ill;
      ill = 1'b1;
      if (op[1:0] == 2'b11) begin
         case (op)
            7'b0110111,
            7'b0010111,
            7'b1101111,
            7'b1100111,
            7'b1100011,
            7'b0000011,
            7'b0100011,
            7'b0010011,
            7'b0110011,
            7'b0001111,
            7'b1110011: ill = 1'b0;
            default:    ill = 1'b1;
         endcase
      end
      return ill;
   endfunction

   // A taken redirect must reach the PC register even while decode is stalled.
   assign o_if_en = ~i_stall | i_flush;

   // Resolve reset > flush > stall > load into a single update selector.
   always_comb begin
      upd_sel = UPD_LOAD;
      if (i_rst) begin
         upd_sel = UPD_RESET;
      end else if (i_flush) begin
         upd_sel = UPD_FLUSH;
      end else if (i_stall) begin
         upd_sel = UPD_STALL;
      end
   end

   // Legality of the incoming word, computed ahead of the register so the flag is registered.
   always_comb begin
      in_illegal = is_illegal(i_instr[6:0]);
   end

   // Pipeline payload: valid, PC pair, instruction and its illegal flag.
   always_ff @(posedge i_clk) begin
      case (upd_sel)
         UPD_RESET: begin
            o_valid   <= 1'b0;
            o_pc      <= RESET_PC;
            o_inc_pc  <= RESET_INC_PC;
            o_instr   <= NOP_INSTR;
            o_illegal <= 1'b0;
         end
         UPD_FLUSH: begin
            o_valid   <= 1'b0;
            o_pc      <= i_pc;
            o_inc_pc  <= i_inc_pc;
            o_instr   <= NOP_INSTR;
            o_illegal <= 1'b0;
         end
         UPD_STALL: begin
            o_valid   <= o_valid;
            o_pc      <= o_pc;
            o_inc_pc  <= o_inc_pc;
            o_instr   <= o_instr;
            o_illegal <= o_illegal;
         end
         default: begin
            o_valid   <= 1'b1;
            o_pc      <= i_pc;
            o_inc_pc  <= i_inc_pc;
            o_instr   <= i_instr;
            o_illegal <= in_illegal;
         end
      endcase
   end

   // Event counters: loads bump the accepted count, flush or stall bumps the bubble count.
   always_ff @(posedge i_clk) begin
      case (upd_sel)
         UPD_RESET: begin
            o_acc_cnt <= '0;
            o_bub_cnt <= '0;
         end
         UPD_FLUSH,
         UPD_STALL: begin
            o_acc_cnt <= o_acc_cnt;
            o_bub_cnt <= o_bub_cnt + CNT_ONE;
         end
         default: begin
            o_acc_cnt <= o_acc_cnt + CNT_ONE;
            o_bub_cnt <= o_bub_cnt;
         end
      endcase
   end

   // Decode fields are plain slices of the registered word, so bubbles show NOP fields.
   assign o_opcode = o_instr[6:0];
   assign o_rd     = o_instr[11:7];
   assign o_funct3 = o_instr[14:12];
   assign o_rs1    = o_instr[19:15];
   assign o_rs2    = o_instr[24:20];
   assign o_funct7 = o_instr[31:25];

endmodule

// File: tb/tb_if_id_reg.sv
// Self-checking bench for if_id_reg: table of vectors plus hand sequences for
// counter wrap and reset during stall. A narrow-counter instance shares stimulus.
module tb_if_id_reg;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stall = 1'b1;
   logic        flush = 1'b0;
   logic [31:0] pc = '0;
   logic [31:0] inc_pc = 32'd4;
   logic [31:0] instr = 32'hFFFFFFFF;

   logic        if_en, valid, illegal;
   logic [31:0] o_pc, o_inc_pc, o_instr;
   logic [6:0]  opcode, funct7;
   logic [4:0]  rd, rs1, rs2;
   logic [2:0]  funct3;
   logic [31:0] acc_cnt, bub_cnt;

   logic        if_en4, valid4, illegal4;
   logic [31:0] o_pc4, o_inc_pc4, o_instr4;
   logic [6:0]  opcode4, funct74;
   logic [4:0]  rd4, rs14, rs24;
   logic [2:0]  funct34;
   logic [3:0]  acc_cnt4, bub_cnt4;

   int checks = 0;
   int fails  = 0;
   logic [31:0] mdl_acc = '0;
   logic [31:0] mdl_bub = '0;

   typedef struct {
      logic        valid;
      logic [31:0] pc;
      logic [31:0] instr;
      logic        ill;
      logic [31:0] acc;
      logic [31:0] bub;
   } exp_t;

   typedef struct {
      logic        r, s, f;
      logic [31:0] pc, instr;
      logic        e_if_en, e_valid;
      logic [31:0] e_pc, e_instr;
      logic        e_ill;
   } vec_t;

   exp_t sbq[$];
   vec_t vecs[18];

   if_id_reg dut (
      .i_clk(clk), .i_rst(rst), .i_stall(stall), .i_flush(flush),
      .i_pc(pc), .i_inc_pc(inc_pc), .i_instr(instr),
      .o_if_en(if_en), .o_valid(valid), .o_pc(o_pc), .o_inc_pc(o_inc_pc),
      .o_instr(o_instr), .o_opcode(opcode), .o_rd(rd), .o_funct3(funct3),
      .o_rs1(rs1), .o_rs2(rs2), .o_funct7(funct7), .o_illegal(illegal),
      .o_acc_cnt(acc_cnt), .o_bub_cnt(bub_cnt)
   );

   if_id_reg #(.CNT_W(4)) dut4 (
      .i_clk(clk), .i_rst(rst), .i_stall(stall), .i_flush(flush),
      .i_pc(pc), .i_inc_pc(inc_pc), .i_instr(instr),
      .o_if_en(if_en4), .o_valid(valid4), .o_pc(o_pc4), .o_inc_pc(o_inc_pc4),
      .o_instr(o_instr4), .o_opcode(opcode4), .o_rd(rd4), .o_funct3(funct34),
      .o_rs1(rs14), .o_rs2(rs24), .o_funct7(funct74), .o_illegal(illegal4),
      .o_acc_cnt(acc_cnt4), .o_bub_cnt(bub_cnt4)
   );

   always #5 clk = ~clk;

   // Compare one value and report a mismatch.
   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Pop the oldest expectation and compare every registered output against it.
   task automatic checkOutput();
      exp_t e;
      if (sbq.size() == 0) begin
         checks++;
         fails++;
         $display("[TB] FAIL scoreboard: got empty queue expected an entry");
      end else begin
         e = sbq.pop_front();
         check32("valid", {31'b0, valid}, {31'b0, e.valid});
         check32("pc", o_pc, e.pc);
         check32("inc_pc", o_inc_pc, e.pc + 32'd4);
         check32("instr", o_instr, e.instr);
         check32("decode", {opcode, rd, funct3, rs1, rs2, funct7},
                 {e.instr[6:0], e.instr[11:7], e.instr[14:12], e.instr[19:15],
                  e.instr[24:20], e.instr[31:25]});
         check32("illegal", {31'b0, illegal}, {31'b0, e.ill});
         check32("acc_cnt", acc_cnt, e.acc);
         check32("bub_cnt", bub_cnt, e.bub);
         check32("acc_cnt4", {28'b0, acc_cnt4}, {28'b0, e.acc[3:0]});
         check32("bub_cnt4", {28'b0, bub_cnt4}, {28'b0, e.bub[3:0]});
      end
   endtask

   // Drive one cycle of inputs, check the combinational enable, queue the expected result.
   task automatic applyStimulus(input logic r, input logic s, input logic f,
                                input logic [31:0] p, input logic [31:0] ins,
                                input logic e_if_en, input logic e_valid,
                                input logic [31:0] e_pc, input logic [31:0] e_instr,
                                input logic e_ill);
      exp_t e;
      @(negedge clk);
      rst = r;
      stall = s;
      flush = f;
      pc = p;
      inc_pc = p + 32'd4;
      instr = ins;
      #1;
      check32("if_en", {31'b0, if_en}, {31'b0, e_if_en});
      if (r) begin
         mdl_acc = '0;
         mdl_bub = '0;
      end else if (f || s) begin
         mdl_bub = mdl_bub + 32'd1;
      end else begin
         mdl_acc = mdl_acc + 32'd1;
      end
      e.valid = e_valid;
      e.pc = e_pc;
      e.instr = e_instr;
      e.ill = e_ill;
      e.acc = mdl_acc;
      e.bub = mdl_bub;
      sbq.push_back(e);
      @(posedge clk);
      #1;
      checkOutput();
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got no finish expected finish before timeout");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      //            r  s  f  pc          instr          if_en valid e_pc        e_instr        ill
      vecs[0]  = '{1, 1, 0, 32'h40, 32'hFFFFFFFF, 0, 0, 32'h00, 32'h00000013, 0};
      vecs[1]  = '{1, 1, 0, 32'h44, 32'hFFFFFFFF, 0, 0, 32'h00, 32'h00000013, 0};
      vecs[2]  = '{0, 0, 0, 32'h00, 32'h00500093, 1, 1, 32'h00, 32'h00500093, 0};
      vecs[3]  = '{0, 0, 0, 32'h04, 32'h00208133, 1, 1, 32'h04, 32'h00208133, 0};
      vecs[4]  = '{0, 0, 0, 32'h08, 32'h002081B3, 1, 1, 32'h08, 32'h002081B3, 0};
      vecs[5]  = '{0, 0, 0, 32'h10, 32'h00A00113, 1, 1, 32'h10, 32'h00A00113, 0};
      vecs[6]  = '{0, 1, 0, 32'h14, 32'hFFFFFFFF, 0, 1, 32'h10, 32'h00A00113, 0};
      vecs[7]  = '{0, 1, 0, 32'h18, 32'h0000007F, 0, 1, 32'h10, 32'h00A00113, 0};
      vecs[8]  = '{0, 1, 0, 32'h1C, 32'h00000000, 0, 1, 32'h10, 32'h00A00113, 0};
      vecs[9]  = '{0, 1, 1, 32'h20, 32'h00000033, 1, 0, 32'h20, 32'h00000013, 0};
      vecs[10] = '{0, 0, 0, 32'h24, 32'h0000007F, 1, 1, 32'h24, 32'h0000007F, 1};
      vecs[11] = '{0, 0, 0, 32'h28, 32'h00000013, 1, 1, 32'h28, 32'h00000013, 0};
      vecs[12] = '{0, 0, 0, 32'h2C, 32'h00000000, 1, 1, 32'h2C, 32'h00000000, 1};
      vecs[13] = '{0, 0, 1, 32'h30, 32'h00000033, 1, 0, 32'h30, 32'h00000013, 0};
      vecs[14] = '{0, 0, 0, 32'h34, 32'h00000002, 1, 1, 32'h34, 32'h00000002, 1};
      vecs[15] = '{0, 0, 0, 32'h38, 32'h00000073, 1, 1, 32'h38, 32'h00000073, 0};
      vecs[16] = '{0, 1, 0, 32'h3C, 32'h0000006F, 0, 1, 32'h38, 32'h00000073, 0};
      vecs[17] = '{1, 1, 1, 32'h40, 32'h0000007F, 1, 0, 32'h00, 32'h00000013, 0};

      for (int i = 0; i < 18; i++) begin
         applyStimulus(vecs[i].r, vecs[i].s, vecs[i].f, vecs[i].pc, vecs[i].instr,
                       vecs[i].e_if_en, vecs[i].e_valid, vecs[i].e_pc,
                       vecs[i].e_instr, vecs[i].e_ill);
         if (i == 4) begin
            check32("rd_fields", {17'b0, rd, rd4, 5'b0}, {17'b0, 5'd3, 5'd3, 5'b0});
         end
      end

      // Sixteen loads: the 4-bit accepted counter must come back to zero.
      for (int i = 0; i < 16; i++) begin
         applyStimulus(1'b0, 1'b0, 1'b0, 32'(i * 4), 32'h00000013,
                       1'b1, 1'b1, 32'(i * 4), 32'h00000013, 1'b0);
      end
      check32("acc_wrap4", {28'b0, acc_cnt4}, 32'd0);
      check32("acc_16", acc_cnt, 32'd16);

      // Sixteen stalls: contents hold and the 4-bit bubble counter wraps.
      for (int i = 0; i < 16; i++) begin
         applyStimulus(1'b0, 1'b1, 1'b0, 32'h100 + 32'(i * 4), 32'h0000007F,
                       1'b0, 1'b1, 32'd60, 32'h00000013, 1'b0);
      end
      check32("bub_wrap4", {28'b0, bub_cnt4}, 32'd0);

      // Reset asserted while stalled clears valid and counters on the next edge.
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h200, 32'h0000007F,
                    1'b0, 1'b0, 32'h00, 32'h00000013, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h204, 32'h00208133,
                    1'b1, 1'b1, 32'h204, 32'h00208133, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
